// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state encoding and requester port indices.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccCpu = 2'd1,
        StAccDbg = 2'd2
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    function automatic arb_state_e acc_state(input logic port);
        return (port == PORT_DBG) ? StAccDbg : StAccCpu;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational 2-way request picker. MEM_ARB_ROUND_ROBIN_EN selects round-robin on ties;
// otherwise the CPU port has fixed priority.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        valid  = |req;
        winner = PORT_CPU;
        if (req[PORT_CPU] && req[PORT_DBG]) begin
            winner = ~last;
        end else if (req[PORT_DBG]) begin
            winner = PORT_DBG;
        end
    end
`else
    // Pointer is only meaningful in round-robin builds.
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        valid  = |req;
        winner = PORT_CPU;
        if (!req[PORT_CPU] && req[PORT_DBG]) begin
            winner = PORT_DBG;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a negedge-clocked single-port memory between the CPU and debug ports, one access per
// two clocks, registered outputs. Build option MEM_ARB_ROUND_ROBIN_EN (see arb_pick).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned RAM_ADDR_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [RAM_ADDR_BITS-1:0] cpu_adr,
    input  logic [WIDTH-1:0]         cpu_wdata,
    output logic                     cpu_gnt,
    output logic                     cpu_done,
    output logic [WIDTH-1:0]         cpu_rdata,

    input  logic                     dbg_req,
    input  logic                     dbg_we,
    input  logic [RAM_ADDR_BITS-1:0] dbg_adr,
    input  logic [WIDTH-1:0]         dbg_wdata,
    output logic                     dbg_gnt,
    output logic                     dbg_done,
    output logic [WIDTH-1:0]         dbg_rdata,

    output logic                     mem_en,
    output logic                     mem_we,
    output logic [RAM_ADDR_BITS-1:0] mem_adr,
    output logic [WIDTH-1:0]         mem_wdata,
    input  logic [WIDTH-1:0]         mem_rdata
);

    arb_state_e               state_q, state_d;
    logic                     last_q, last_d;
    logic                     mem_en_q, mem_en_d;
    logic                     mem_we_q, mem_we_d;
    logic [RAM_ADDR_BITS-1:0] mem_adr_q, mem_adr_d;
    logic [WIDTH-1:0]         mem_wdata_q, mem_wdata_d;
    logic                     cpu_gnt_q, cpu_gnt_d;
    logic                     dbg_gnt_q, dbg_gnt_d;
    logic                     cpu_done_q, cpu_done_d;
    logic                     dbg_done_q, dbg_done_d;
    logic [WIDTH-1:0]         cpu_rdata_q, cpu_rdata_d;
    logic [WIDTH-1:0]         dbg_rdata_q, dbg_rdata_d;

    logic pick_valid;
    logic pick_winner;

    arb_pick u_arb_pick (
        .req    ({dbg_req, cpu_req}),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_adr_d   = mem_adr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_gnt_d   = 1'b0;
        dbg_gnt_d   = 1'b0;
        cpu_done_d  = 1'b0;
        dbg_done_d  = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    mem_en_d = 1'b1;
                    last_d   = pick_winner;
                    state_d  = acc_state(pick_winner);
                    if (pick_winner == PORT_DBG) begin
                        mem_we_d    = dbg_we;
                        mem_adr_d   = dbg_adr;
                        mem_wdata_d = dbg_wdata;
                        dbg_gnt_d   = 1'b1;
                    end else begin
                        mem_we_d    = cpu_we;
                        mem_adr_d   = cpu_adr;
                        mem_wdata_d = cpu_wdata;
                        cpu_gnt_d   = 1'b1;
                    end
                end
            end
            // Memory completed the access on the falling edge inside this cycle.
            StAccCpu: begin
                cpu_rdata_d = mem_rdata;
                cpu_done_d  = 1'b1;
                state_d     = StIdle;
            end
            StAccDbg: begin
                dbg_rdata_d = mem_rdata;
                dbg_done_d  = 1'b1;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            last_q      <= PORT_CPU;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_adr_q   <= '0;
            mem_wdata_q <= '0;
            cpu_gnt_q   <= 1'b0;
            dbg_gnt_q   <= 1'b0;
            cpu_done_q  <= 1'b0;
            dbg_done_q  <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_gnt_q   <= cpu_gnt_d;
            dbg_gnt_q   <= dbg_gnt_d;
            cpu_done_q  <= cpu_done_d;
            dbg_done_q  <= dbg_done_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_adr   = mem_adr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_gnt   = cpu_gnt_q;
    assign dbg_gnt   = dbg_gnt_q;
    assign cpu_done  = cpu_done_q;
    assign dbg_done  = dbg_done_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a negedge-clocked read-before-write 256x8 memory model.
module tb_mem_arbiter;

    logic       clk;
    logic       reset;
    logic       cpu_req, cpu_we, cpu_gnt, cpu_done;
    logic [7:0] cpu_adr, cpu_wdata, cpu_rdata;
    logic       dbg_req, dbg_we, dbg_gnt, dbg_done;
    logic [7:0] dbg_adr, dbg_wdata, dbg_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_adr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter #(
        .WIDTH         (8),
        .RAM_ADDR_BITS (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_adr   (cpu_adr),
        .cpu_wdata (cpu_wdata),
        .cpu_gnt   (cpu_gnt),
        .cpu_done  (cpu_done),
        .cpu_rdata (cpu_rdata),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_adr   (dbg_adr),
        .dbg_wdata (dbg_wdata),
        .dbg_gnt   (dbg_gnt),
        .dbg_done  (dbg_done),
        .dbg_rdata (dbg_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: preloaded on the first falling edge, before any access can be enabled.
    logic [7:0] mem [256];
    bit         loaded = 1'b0;
    always @(negedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'h00;
            mem[8'h10] = 8'hA5;
            mem[8'h20] = 8'h11;
            mem[8'hFF] = 8'h5A;
            mem[8'h00] = 8'hC3;
            loaded = 1'b1;
        end else if (mem_en) begin
            mem_rdata <= mem[mem_adr];
            if (mem_we) mem[mem_adr] = mem_wdata;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Called at #1 after a rising edge; returns at #1 after the edge that raised done.
    task automatic do_access(input bit is_dbg, input bit we, input logic [7:0] adr,
                             input logic [7:0] wd, input logic [7:0] exp_rd, input string tag,
                             output int waits);
        bit got;
        if (is_dbg) begin
            dbg_req = 1'b1; dbg_we = we; dbg_adr = adr; dbg_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_wdata = wd;
        end
        got   = 1'b0;
        waits = 0;
        for (int i = 1; i <= 10 && !got; i++) begin
            @(posedge clk); #1;
            waits = i;
            got   = is_dbg ? dbg_gnt : cpu_gnt;
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        if (!got) begin
            check_val({tag, " gnt timeout"}, 0, 1);
            return;
        end
        check_val({tag, " mem_en"}, 32'(mem_en), 1);
        check_val({tag, " mem_adr"}, 32'(mem_adr), 32'(adr));
        check_val({tag, " mem_we"}, 32'(mem_we), 32'(we));
        if (we) check_val({tag, " mem_wdata"}, 32'(mem_wdata), 32'(wd));
        check_val({tag, " other gnt"}, 32'(is_dbg ? cpu_gnt : dbg_gnt), 0);
        @(posedge clk); #1;
        check_val({tag, " done"}, 32'(is_dbg ? dbg_done : cpu_done), 1);
        check_val({tag, " rdata"}, 32'(is_dbg ? dbg_rdata : cpu_rdata), 32'(exp_rd));
        check_val({tag, " gnt drop"}, 32'(is_dbg ? dbg_gnt : cpu_gnt), 0);
        check_val({tag, " en drop"}, 32'(mem_en), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n_grants;
        int dbg_seen;
        int seq [8];
        reset   = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 8'h00; cpu_wdata = 8'h00;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_adr = 8'h00; dbg_wdata = 8'h00;

        // Reset held two cycles with both requests asserted.
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check_val("rst mem_en", 32'(mem_en), 0);
            check_val("rst gnt", 32'({cpu_gnt, dbg_gnt}), 0);
            check_val("rst done", 32'({cpu_done, dbg_done}), 0);
            check_val("rst mem_adr", 32'(mem_adr), 0);
            check_val("rst rdata", 32'({cpu_rdata, dbg_rdata}), 0);
        end
        reset   = 1'b0;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        @(posedge clk); #1;
        check_val("idle mem_en", 32'(mem_en), 0);
        check_val("idle gnt", 32'({cpu_gnt, dbg_gnt}), 0);

        do_access(1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, "cpu_rd10", w);
        check_val("cpu_rd10 latency", 32'(w), 1);

        do_access(1'b1, 1'b1, 8'h20, 8'h3C, 8'h11, "dbg_wr20", w);
        do_access(1'b0, 1'b0, 8'h20, 8'h00, 8'h3C, "cpu_rd20", w);
        check_val("dbg_rdata hold", 32'(dbg_rdata), 'h11);

        do_access(1'b0, 1'b0, 8'hFF, 8'h00, 8'h5A, "cpu_rdFF", w);
        do_access(1'b0, 1'b0, 8'h00, 8'h00, 8'hC3, "cpu_rd00", w);
        check_val("b2b gnt spacing", 32'(w), 1);

        // Leave debug as last served so a round-robin tie starts with the CPU.
        do_access(1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, "dbg_rd10", w);

        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 8'h10;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_adr = 8'h20;
        n_grants = 0;
        dbg_seen = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            if (cpu_gnt && dbg_gnt) check_val("dual gnt", 1, 0);
            if (dbg_gnt) dbg_seen++;
            if ((cpu_gnt || dbg_gnt) && n_grants < 8) seq[n_grants] = dbg_gnt ? 1 : 0;
            if (cpu_gnt || dbg_gnt) n_grants++;
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        check_val("tie grant count", 32'(n_grants), 8);
        for (int k = 0; k < 8; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            check_val($sformatf("rr grant %0d", k), 32'(seq[k]), 32'(k % 2));
`else
            check_val($sformatf("fixed grant %0d", k), 32'(seq[k]), 0);
`endif
        end
`ifndef MEM_ARB_ROUND_ROBIN_EN
        check_val("dbg starved", 32'(dbg_seen), 0);
`endif
        check_val("tie cpu_rdata", 32'(cpu_rdata), 'hA5);
        @(posedge clk); #1;
        check_val("post-tie idle", 32'(mem_en), 0);

        // Reset lands on the edge that would end a CPU write.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_adr = 8'h05; cpu_wdata = 8'h77;
        @(posedge clk); #1;
        check_val("rstacc gnt", 32'(cpu_gnt), 1);
        reset   = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        check_val("rstacc done", 32'(cpu_done), 0);
        check_val("rstacc mem_en", 32'(mem_en), 0);
        check_val("rstacc cpu_rdata", 32'(cpu_rdata), 0);
        check_val("rstacc dbg_rdata", 32'(dbg_rdata), 0);
        @(posedge clk); #1;
        check_val("rstacc done2", 32'(cpu_done), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        do_access(1'b0, 1'b0, 8'h05, 8'h00, 8'h77, "cpu_rd05", w);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
